// File: rtl/pkt_switch_pkg.sv
// Shared types and defaults for the packet switch ingress/scheduler slice.
package pkt_switch_pkg;

  localparam int DEFAULT_N_PORTS   = 4;
  localparam int DEFAULT_IDX_WIDTH = 2;
  localparam int DROP_CNT_WIDTH    = 16;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_STORE = 2'd1,
    WR_DROP  = 2'd2
  } wr_state_t;

  typedef struct packed {
    logic [DEFAULT_IDX_WIDTH-1:0] dst;
  } frame_desc_t;

endpackage

// File: rtl/frame_desc_fifo.sv
// Descriptor FIFO: one entry per committed frame resident in the data buffer.
module frame_desc_fifo
  import pkt_switch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic        pop,
  input  frame_desc_t din,
  output frame_desc_t dout,
  output logic [AW:0] count,
  output logic        full
);

  frame_desc_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign count = wr_ptr - rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ingress_frame_queue.sv
// Store-and-forward ingress frame buffer: frames become visible to the
// schedulers only once fully received, so valid never drops mid-frame.
//
// state    | meaning
// WR_IDLE  | between frames, next accepted beat starts a frame
// WR_STORE | frame in progress, beats written speculatively at wr_spec
// WR_DROP  | frame rejected (no room), discarding beats until last
module ingress_frame_queue
  import pkt_switch_pkg::*;
#(
  parameter int N_PORTS    = DEFAULT_N_PORTS,
  parameter int IDX_WIDTH  = DEFAULT_IDX_WIDTH,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int PTR_WIDTH  = 6,
  parameter int MAX_FRAMES = 8,
  localparam int FC_WIDTH  = $clog2(MAX_FRAMES) + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [IDX_WIDTH-1:0]      in_dst,
  output logic                      in_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [IDX_WIDTH-1:0]      out_dst,
  input  logic                      out_ready,
  output logic [FC_WIDTH-1:0]       frame_count,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  if (DEPTH != (1 << PTR_WIDTH) || N_PORTS > (1 << IDX_WIDTH)
      || IDX_WIDTH != DEFAULT_IDX_WIDTH) begin : g_cfg_check
    $error("ingress_frame_queue: inconsistent DEPTH/PTR_WIDTH/N_PORTS/IDX_WIDTH");
  end

  logic [DATA_WIDTH:0]  mem [DEPTH];
  logic [PTR_WIDTH:0]   wr_spec;
  logic [PTR_WIDTH:0]   wr_commit;
  logic [PTR_WIDTH:0]   rd_ptr;
  wr_state_t            wr_state;
  wr_state_t            wr_state_nxt;
  frame_desc_t          cur_desc;
  frame_desc_t          push_desc;
  frame_desc_t          head_desc;
  logic [DATA_WIDTH:0]  head_beat;
  logic                 beat_acc;
  logic                 buf_full;
  logic                 desc_full;
  logic                 mem_we;
  logic                 push;
  logic                 pop;
  logic                 rd_fire;
  logic                 drop_inc;
  logic                 spec_rewind;
  logic                 latch_dst;

  assign beat_acc = in_valid && in_ready;
  assign buf_full = (wr_spec[PTR_WIDTH] != rd_ptr[PTR_WIDTH])
                 && (wr_spec[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);

  always_comb begin
    wr_state_nxt = wr_state;
    mem_we       = 1'b0;
    push         = 1'b0;
    drop_inc     = 1'b0;
    spec_rewind  = 1'b0;
    latch_dst    = 1'b0;
    if (beat_acc) begin
      case (wr_state)
        WR_IDLE: begin
          if (desc_full || buf_full) begin
            spec_rewind = 1'b1;
            if (in_last) drop_inc = 1'b1;
            else         wr_state_nxt = WR_DROP;
          end else begin
            mem_we    = 1'b1;
            latch_dst = 1'b1;
            if (in_last) push = 1'b1;
            else         wr_state_nxt = WR_STORE;
          end
        end
        WR_STORE: begin
          if (buf_full) begin
            spec_rewind = 1'b1;
            if (in_last) drop_inc = 1'b1;
            wr_state_nxt = in_last ? WR_IDLE : WR_DROP;
          end else begin
            mem_we = 1'b1;
            if (in_last) begin
              push         = 1'b1;
              wr_state_nxt = WR_IDLE;
            end
          end
        end
        WR_DROP: begin
          if (in_last) begin
            drop_inc     = 1'b1;
            wr_state_nxt = WR_IDLE;
          end
        end
        default: wr_state_nxt = WR_IDLE;
      endcase
    end
  end

  // A single-beat frame commits with the dst it arrives with, not the latched one.
  assign push_desc.dst = (wr_state == WR_IDLE) ? in_dst : cur_desc.dst;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state     <= WR_IDLE;
      wr_spec      <= '0;
      wr_commit    <= '0;
      rd_ptr       <= '0;
      cur_desc     <= '0;
      drop_count   <= '0;
      in_ready     <= 1'b0;
    end else begin
      in_ready <= 1'b1;
      wr_state <= wr_state_nxt;
      if (latch_dst) cur_desc.dst <= in_dst;
      if (spec_rewind) begin
        wr_spec <= wr_commit;
      end else if (mem_we) begin
        wr_spec <= wr_spec + 1'b1;
        if (push) wr_commit <= wr_spec + 1'b1;
      end
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      if (drop_inc && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_spec[PTR_WIDTH-1:0]] <= {in_last, in_data};
  end

  frame_desc_fifo #(
    .DEPTH (MAX_FRAMES)
  ) u_desc_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (push_desc),
    .dout    (head_desc),
    .count   (frame_count),
    .full    (desc_full)
  );

  // Storage is not reset, so the read port is forced to zero when nothing is offered.
  assign head_beat = mem[rd_ptr[PTR_WIDTH-1:0]];
  assign out_valid = (frame_count != '0);
  assign out_data  = out_valid ? head_beat[DATA_WIDTH-1:0] : '0;
  assign out_last  = out_valid && head_beat[DATA_WIDTH];
  assign out_dst   = out_valid ? head_desc.dst : '0;
  assign rd_fire   = out_valid && out_ready;
  assign pop       = rd_fire && head_beat[DATA_WIDTH];

endmodule

// File: tb/tb_ingress_frame_queue.sv
// Self-checking bench for ingress_frame_queue: directed table, corner sequences
// and random traffic against a queue-based frame model.
module tb_ingress_frame_queue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [1:0]  in_dst = '0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  out_dst;
  logic        out_ready = 1'b0;
  logic [3:0]  frame_count;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  ingress_frame_queue dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_dst      (in_dst),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_dst     (out_dst),
    .out_ready   (out_ready),
    .frame_count (frame_count),
    .drop_count  (drop_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames as beat lists; a frame joins beat_q only when complete.
  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t      beat_q[$];
  beat_t      part_q[$];
  logic [1:0] dst_q[$];
  logic [1:0] cur_dst;
  bit         m_dropping;
  bit         m_rdy;
  int         m_drop;

  task automatic model_reset();
    beat_q.delete();
    part_q.delete();
    dst_q.delete();
    cur_dst    = '0;
    m_dropping = 0;
    m_rdy      = 0;
    m_drop     = 0;
  endtask

  task automatic model_drop_frame();
    if (m_drop < 65535) m_drop++;
  endtask

  task automatic model_edge();
    int    occ;
    int    frames_pre;
    beat_t b;
    if (!reset_n) begin
      model_reset();
      return;
    end
    occ        = beat_q.size() + part_q.size();
    frames_pre = dst_q.size();
    if (frames_pre != 0 && out_ready) begin
      b = beat_q.pop_front();
      if (b.last) void'(dst_q.pop_front());
    end
    if (in_valid && m_rdy) begin
      if (m_dropping) begin
        if (in_last) begin
          m_dropping = 0;
          model_drop_frame();
        end
      end else if ((part_q.size() == 0 && frames_pre == 8) || occ == 64) begin
        part_q.delete();
        if (in_last) model_drop_frame();
        else         m_dropping = 1;
      end else begin
        if (part_q.size() == 0) cur_dst = in_dst;
        b.data = in_data;
        b.last = in_last;
        part_q.push_back(b);
        if (in_last) begin
          foreach (part_q[k]) beat_q.push_back(part_q[k]);
          dst_q.push_back(cur_dst);
          part_q.delete();
        end
      end
    end
    m_rdy = 1;
  endtask

  task automatic check_model(input string tag);
    bit v;
    v = (dst_q.size() != 0);
    chk({tag, ".in_ready"},    in_ready,    m_rdy);
    chk({tag, ".out_valid"},   out_valid,   v);
    chk({tag, ".out_data"},    out_data,    v ? beat_q[0].data : 8'h00);
    chk({tag, ".out_last"},    out_last,    v ? beat_q[0].last : 1'b0);
    chk({tag, ".out_dst"},     out_dst,     v ? dst_q[0] : 2'd0);
    chk({tag, ".frame_count"}, frame_count, dst_q.size());
    chk({tag, ".drop_count"},  drop_count,  m_drop);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (tag != "") check_model(tag);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l,
                       input logic [1:0] dst, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    in_dst    = dst;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    drive(0, 8'h00, 0, 2'd0, 0);
    repeat (2) cycle("rst");
    reset_n = 1'b1;
    cycle("rel");
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       il;
    logic [1:0] idst;
    logic       ordy;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic [1:0] edst;
    logic [3:0] efc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int rate;
    tbl[0] = '{1, 8'h11, 0, 2'd2, 0,  0, 8'h00, 0, 2'd0, 4'd0};
    tbl[1] = '{1, 8'h22, 0, 2'd0, 0,  0, 8'h00, 0, 2'd0, 4'd0};
    tbl[2] = '{1, 8'h33, 1, 2'd1, 0,  1, 8'h11, 0, 2'd2, 4'd1};
    tbl[3] = '{0, 8'h00, 0, 2'd0, 0,  1, 8'h11, 0, 2'd2, 4'd1};
    tbl[4] = '{0, 8'h00, 0, 2'd0, 1,  1, 8'h22, 0, 2'd2, 4'd1};
    tbl[5] = '{0, 8'h00, 0, 2'd0, 1,  1, 8'h33, 1, 2'd2, 4'd1};
    tbl[6] = '{0, 8'h00, 0, 2'd0, 1,  0, 8'h00, 0, 2'd0, 4'd0};

    model_reset();
    @(negedge clk);
    check_model("reset");
    chk("reset.in_ready", in_ready, 1'b0);
    reset_n = 1'b1;
    cycle("release");
    chk("release.in_ready", in_ready, 1'b1);

    // 3-beat frame held back, then drained back-to-back
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].iv, tbl[i].id, tbl[i].il, tbl[i].idst, tbl[i].ordy);
      cycle("");
      chk($sformatf("tbl[%0d].out_valid", i),   out_valid,   tbl[i].ev);
      chk($sformatf("tbl[%0d].out_data", i),    out_data,    tbl[i].ed);
      chk($sformatf("tbl[%0d].out_last", i),    out_last,    tbl[i].el);
      chk($sformatf("tbl[%0d].out_dst", i),     out_dst,     tbl[i].edst);
      chk($sformatf("tbl[%0d].frame_count", i), frame_count, tbl[i].efc);
      chk($sformatf("tbl[%0d].in_ready", i),    in_ready,    1'b1);
    end

    // Nine single-beat frames against an 8-entry descriptor FIFO
    for (int i = 0; i < 9; i++) begin
      drive(1, 8'hA0 + 8'(i), 1, 2'(i), 0);
      cycle("desc_full");
    end
    drive(0, 8'h00, 0, 2'd0, 0);
    cycle("desc_full");
    chk("desc_full.frame_count", frame_count, 4'd8);
    chk("desc_full.drop_count",  drop_count,  16'd1);
    chk("desc_full.in_ready",    in_ready,    1'b1);
    drive(0, 8'h00, 0, 2'd0, 1);
    repeat (9) cycle("desc_drain");
    chk("desc_drain.out_valid", out_valid, 1'b0);

    // Data buffer overflow: 40-beat frame resident, 30-beat frame overflows
    do_reset();
    for (int i = 0; i < 40; i++) begin
      drive(1, 8'(i), (i == 39), 2'd1, 0);
      cycle("ovf_a");
    end
    for (int i = 0; i < 30; i++) begin
      drive(1, 8'h80 + 8'(i), (i == 29), 2'd2, 0);
      cycle("ovf_b");
    end
    drive(0, 8'h00, 0, 2'd0, 0);
    cycle("ovf");
    chk("ovf.frame_count", frame_count, 4'd1);
    chk("ovf.drop_count",  drop_count,  16'd1);
    chk("ovf.out_dst",     out_dst,     2'd1);
    chk("ovf.out_data",    out_data,    8'd0);
    drive(0, 8'h00, 0, 2'd0, 1);
    repeat (40) cycle("ovf_drain");
    chk("ovf_drain.out_valid", out_valid, 1'b0);
    drive(1, 8'h5A, 1, 2'd3, 0);
    cycle("ovf_after");
    chk("ovf_after.out_data", out_data, 8'h5A);
    chk("ovf_after.out_dst",  out_dst,  2'd3);
    drive(0, 8'h00, 0, 2'd0, 1);
    cycle("ovf_after");

    // Commit of one frame in the same cycle as the pop of another
    drive(1, 8'h51, 0, 2'd1, 0); cycle("same");
    drive(1, 8'h52, 1, 2'd0, 0); cycle("same");
    drive(1, 8'h61, 0, 2'd3, 1); cycle("same");
    drive(1, 8'h62, 1, 2'd0, 1); cycle("same");
    chk("same.frame_count", frame_count, 4'd1);
    chk("same.out_dst",     out_dst,     2'd3);
    chk("same.out_data",    out_data,    8'h61);
    drive(0, 8'h00, 0, 2'd0, 1);
    repeat (3) cycle("same_drain");

    // Reset asserted mid-frame with two frames resident
    drive(1, 8'h01, 1, 2'd1, 0); cycle("mid");
    drive(1, 8'h02, 1, 2'd2, 0); cycle("mid");
    drive(1, 8'h03, 0, 2'd3, 0); cycle("mid");
    drive(1, 8'h04, 0, 2'd3, 0); cycle("mid");
    chk("mid.frame_count", frame_count, 4'd2);
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst.in_ready",    in_ready,    1'b0);
    chk("async_rst.out_valid",   out_valid,   1'b0);
    chk("async_rst.out_last",    out_last,    1'b0);
    chk("async_rst.out_data",    out_data,    8'h00);
    chk("async_rst.out_dst",     out_dst,     2'd0);
    chk("async_rst.frame_count", frame_count, 4'd0);
    chk("async_rst.drop_count",  drop_count,  16'd0);
    drive(0, 8'h00, 0, 2'd0, 0);
    repeat (2) cycle("rst_hold");
    reset_n = 1'b1;
    cycle("rst_rel");
    drive(1, 8'h77, 1, 2'd2, 0);
    cycle("post_rst");
    chk("post_rst.out_valid", out_valid, 1'b1);
    chk("post_rst.out_data",  out_data,  8'h77);
    chk("post_rst.out_last",  out_last,  1'b1);
    chk("post_rst.out_dst",   out_dst,   2'd2);
    drive(0, 8'h00, 0, 2'd0, 1);
    cycle("post_rst");

    // Random traffic with alternating slow and fast drain phases
    rate = 80;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) rate = (rate == 80) ? 8 : 80;
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 6) == 0,
            2'($urandom), $urandom_range(0, 99) < rate);
      cycle("rnd");
    end
    drive(0, 8'h00, 0, 2'd0, 1);
    repeat (80) cycle("rnd_drain");
    chk("rnd_drain.frame_count", frame_count, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
